// File: rtl/gem_sync_mon_n.sv
// GEM fiber sync monitor.
// Each chamber group of fibers, plus the set of all fibers, is checked every
// cycle for matching K-characters. A group counts as good when any unmasked
// fiber carries the overflow K-char, or when all its unmasked fibers agree.
// Each checker runs a LOCKED/ACQUIRE hysteresis FSM, a sticky lost-sync flag
// and a saturating mismatch counter.
// Optional build macro GEM_SYNC_MON_SNAPSHOT_EN adds a capture of the fiber
// bus at the first bad all-fiber cycle (snap_kchar / snap_valid).

// Per-checker lock FSM, sticky flag and error counter.
module gem_sync_mon_grp #(
    parameter int LOCK_CYCLES = 4,
    parameter int ERRCNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                good,
    input  logic                clear,
    output logic                synced,
    output logic                lostsync,
    output logic [ERRCNT_W-1:0] err_cnt
);
    typedef enum logic {LOCKED = 1'b0, ACQUIRE = 1'b1} state_t;

    state_t     state;
    logic [7:0] cnt;

    // Lock hysteresis: one bad cycle drops lock, LOCK_CYCLES good in a row regain it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= LOCKED;
            synced <= 1'b1;
            cnt    <= '0;
        end else begin
            case (state)
                LOCKED: begin
                    if (!good) begin
                        state  <= ACQUIRE;
                        synced <= 1'b0;
                        cnt    <= '0;
                    end
                end
                ACQUIRE: begin
                    if (!good) begin
                        cnt <= '0;
                    end else if (cnt == 8'(LOCK_CYCLES - 1)) begin
                        state  <= LOCKED;
                        synced <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= LOCKED;
                    synced <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Sticky loss flag and saturating mismatch counter; clear beats a bad cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lostsync <= 1'b0;
            err_cnt  <= '0;
        end else if (!good) begin
            lostsync <= 1'b1;
            if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

module gem_sync_mon_n #(
    parameter int                NFIBERS       = 4,
    parameter int                FIBERS_PER_CH = 2,
    parameter int                KWIDTH        = 8,
    parameter logic [KWIDTH-1:0] OVF_KCHAR     = 8'hFC,
    parameter int                LOCK_CYCLES   = 4,
    parameter int                ERRCNT_W      = 16,
    localparam int               NCH           = NFIBERS / FIBERS_PER_CH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NFIBERS*KWIDTH-1:0] kchar_in,
    input  logic [NFIBERS-1:0]        fiber_mask,
    input  logic                      clear_counters,
    output logic [NCH-1:0]            ch_synced,
    output logic                      all_synced,
    output logic [NCH-1:0]            ch_lostsync,
    output logic                      all_lostsync,
    output logic [NCH*ERRCNT_W-1:0]   ch_err_cnt,
    output logic [ERRCNT_W-1:0]       all_err_cnt
`ifdef GEM_SYNC_MON_SNAPSHOT_EN
    ,
    output logic [NFIBERS*KWIDTH-1:0] snap_kchar,
    output logic                      snap_valid
`endif
);
    // Fibers [lo, lo+n) agree, ignoring masked fibers; an overflow K-char anywhere
    // in the span forgives the cycle. Zero or one active fiber is trivially good.
    function automatic logic span_good(input logic [NFIBERS*KWIDTH-1:0] kc,
                                       input logic [NFIBERS-1:0] m,
                                       input int lo, input int n);
        logic              ovf, eq, have;
        logic [KWIDTH-1:0] ref_k;
        ovf   = 1'b0;
        eq    = 1'b1;
        have  = 1'b0;
        ref_k = '0;
        for (int f = 0; f < NFIBERS; f++) begin
            if (f >= lo && f < lo + n && !m[f]) begin
                if (kc[f*KWIDTH +: KWIDTH] == OVF_KCHAR)
                    ovf = 1'b1;
                if (!have) begin
                    ref_k = kc[f*KWIDTH +: KWIDTH];
                    have  = 1'b1;
                end else if (kc[f*KWIDTH +: KWIDTH] != ref_k) begin
                    eq = 1'b0;
                end
            end
        end
        return ovf | eq;
    endfunction

    // Slot NCH is the all-fiber checker; slots 0..NCH-1 are the chamber groups.
    logic [NCH:0]               good_v;
    logic [NCH:0]               synced_v;
    logic [NCH:0]               lost_v;
    logic [NCH:0][ERRCNT_W-1:0] err_v;

    for (genvar g = 0; g <= NCH; g++) begin : g_chk
        if (g < NCH) begin : g_grp
            assign good_v[g] = span_good(kchar_in, fiber_mask, g * FIBERS_PER_CH, FIBERS_PER_CH);
        end else begin : g_all
            assign good_v[g] = span_good(kchar_in, fiber_mask, 0, NFIBERS);
        end

        gem_sync_mon_grp #(
            .LOCK_CYCLES (LOCK_CYCLES),
            .ERRCNT_W    (ERRCNT_W)
        ) u_grp (
            .clock    (clock),
            .reset    (reset),
            .good     (good_v[g]),
            .clear    (clear_counters),
            .synced   (synced_v[g]),
            .lostsync (lost_v[g]),
            .err_cnt  (err_v[g])
        );
    end

    assign ch_synced    = synced_v[NCH-1:0];
    assign all_synced   = synced_v[NCH];
    assign ch_lostsync  = lost_v[NCH-1:0];
    assign all_lostsync = lost_v[NCH];
    assign ch_err_cnt   = err_v[NCH-1:0];
    assign all_err_cnt  = err_v[NCH];

`ifdef GEM_SYNC_MON_SNAPSHOT_EN
    // Capture the bus at the first bad all-fiber cycle; held until reset or clear.
    always_ff @(posedge clock) begin
        if (reset || clear_counters) begin
            snap_kchar <= '0;
            snap_valid <= 1'b0;
        end else if (!good_v[NCH] && !snap_valid) begin
            snap_kchar <= kchar_in;
            snap_valid <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_gem_sync_mon_n.sv
// Randomized bench for gem_sync_mon_n against a history-based reference model:
// sync is "at least LOCK_CYCLES good cycles since the last bad one (or none bad
// since reset)", counters are min(bad cycles since clear, max), sticky is
// "any bad cycle since clear".
module tb_gem_sync_mon_n;
    localparam int NF  = 4;
    localparam int FPC = 2;
    localparam int KW  = 8;
    localparam int LC  = 4;
    localparam int EW  = 4;
    localparam int NCH = NF / FPC;
    localparam int ERRMAX = (1 << EW) - 1;
    localparam logic [KW-1:0] OVF = 8'hFC;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NF*KW-1:0]     kchar_in;
    logic [NF-1:0]        fiber_mask;
    logic                 clear_counters;
    logic [NCH-1:0]       ch_synced;
    logic                 all_synced;
    logic [NCH-1:0]       ch_lostsync;
    logic                 all_lostsync;
    logic [NCH*EW-1:0]    ch_err_cnt;
    logic [EW-1:0]        all_err_cnt;
`ifdef GEM_SYNC_MON_SNAPSHOT_EN
    logic [NF*KW-1:0]     snap_kchar;
    logic                 snap_valid;
`endif

    gem_sync_mon_n #(
        .NFIBERS(NF), .FIBERS_PER_CH(FPC), .KWIDTH(KW), .OVF_KCHAR(OVF),
        .LOCK_CYCLES(LC), .ERRCNT_W(EW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .kchar_in       (kchar_in),
        .fiber_mask     (fiber_mask),
        .clear_counters (clear_counters),
        .ch_synced      (ch_synced),
        .all_synced     (all_synced),
        .ch_lostsync    (ch_lostsync),
        .all_lostsync   (all_lostsync),
        .ch_err_cnt     (ch_err_cnt),
        .all_err_cnt    (all_err_cnt)
`ifdef GEM_SYNC_MON_SNAPSHOT_EN
        ,
        .snap_kchar     (snap_kchar),
        .snap_valid     (snap_valid)
`endif
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state; slot NCH is the all-fiber view.
    int         streak [NCH+1];
    bit         lost   [NCH+1];
    int         errc   [NCH+1];
    bit         m_snapv;
    logic [NF*KW-1:0] m_snap;

    function automatic bit mdl_good(input logic [NF*KW-1:0] kc, input logic [NF-1:0] m,
                                    input int lo, input int n);
        logic [KW-1:0] vals[$];
        for (int f = lo; f < lo + n; f++)
            if (!m[f]) vals.push_back(kc[f*KW +: KW]);
        foreach (vals[i]) if (vals[i] == OVF) return 1'b1;
        foreach (vals[i]) if (vals[i] != vals[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NF*KW-1:0] mk(input logic [KW-1:0] f0, f1, f2, f3);
        return {f3, f2, f1, f0};
    endfunction

    // One clock: drive, advance the model, compare every output.
    task automatic cyc(input logic [NF*KW-1:0] kc, input logic [NF-1:0] m,
                       input bit clr, input bit rst);
        bit g [NCH+1];
        kchar_in = kc; fiber_mask = m; clear_counters = clr; reset = rst;
        for (int i = 0; i < NCH; i++) g[i] = mdl_good(kc, m, i * FPC, FPC);
        g[NCH] = mdl_good(kc, m, 0, NF);
        @(posedge clock);
        #1;
        for (int i = 0; i <= NCH; i++) begin
            if (rst) begin
                streak[i] = 1 << 20; lost[i] = 1'b0; errc[i] = 0;
            end else begin
                streak[i] = g[i] ? ((streak[i] < (1 << 20)) ? streak[i] + 1 : streak[i]) : 0;
                if (clr) begin
                    lost[i] = 1'b0; errc[i] = 0;
                end else if (!g[i]) begin
                    lost[i] = 1'b1;
                    errc[i] = (errc[i] < ERRMAX) ? errc[i] + 1 : ERRMAX;
                end
            end
        end
        if (rst || clr) begin
            m_snapv = 1'b0; m_snap = '0;
        end else if (!g[NCH] && !m_snapv) begin
            m_snapv = 1'b1; m_snap = kc;
        end
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("ch_synced[%0d]", i),   64'(ch_synced[i]),   64'(streak[i] >= LC));
            chk($sformatf("ch_lostsync[%0d]", i), 64'(ch_lostsync[i]), 64'(lost[i]));
            chk($sformatf("ch_err_cnt[%0d]", i),  64'(ch_err_cnt[i*EW +: EW]), 64'(errc[i]));
        end
        chk("all_synced",   64'(all_synced),   64'(streak[NCH] >= LC));
        chk("all_lostsync", 64'(all_lostsync), 64'(lost[NCH]));
        chk("all_err_cnt",  64'(all_err_cnt),  64'(errc[NCH]));
`ifdef GEM_SYNC_MON_SNAPSHOT_EN
        chk("snap_valid", 64'(snap_valid), 64'(m_snapv));
        chk("snap_kchar", 64'(snap_kchar), 64'(m_snap));
`endif
    endtask

    logic [NF*KW-1:0] clean, bad1, hold_pat;
    int hold;

    initial begin
        clean = mk(8'hBC, 8'hBC, 8'hBC, 8'hBC);
        bad1  = mk(8'hBC, 8'h3C, 8'hBC, 8'hBC);
        for (int i = 0; i <= NCH; i++) begin streak[i] = 0; lost[i] = 0; errc[i] = 0; end
        m_snapv = 0; m_snap = '0;
        kchar_in = clean; fiber_mask = '0; clear_counters = 0; reset = 1;

        // Reset state, with a mismatch present during reset.
        repeat (2) cyc(bad1, '0, 1'b0, 1'b1);
        // Clean link.
        repeat (20) cyc(clean, '0, 1'b0, 1'b0);
        // Single-cycle error on fiber 1, then recovery.
        cyc(bad1, '0, 1'b0, 1'b0);
        repeat (8) cyc(clean, '0, 1'b0, 1'b0);
        // Overflow char masks the comparison.
        repeat (3) cyc(mk(8'hFC, 8'h00, 8'hBC, 8'hBC), '0, 1'b0, 1'b0);
        // Masked garbage fiber, then the same unmasked.
        repeat (3) cyc(mk(8'hBC, 8'h5A, 8'hBC, 8'hBC), 4'b0010, 1'b0, 1'b0);
        cyc(mk(8'hBC, 8'h5A, 8'hBC, 8'hBC), 4'b0000, 1'b0, 1'b0);
        repeat (6) cyc(clean, '0, 1'b0, 1'b0);
        // Long mismatch: saturation, clear mid-mismatch, counting resumes.
        for (int i = 0; i < 40; i++) cyc(bad1, '0, (i == 30), 1'b0);
        repeat (5) cyc(clean, '0, 1'b0, 1'b0);
        // Reset while acquiring (two good cycles banked).
        cyc(bad1, '0, 1'b0, 1'b0);
        repeat (2) cyc(clean, '0, 1'b0, 1'b0);
        cyc(clean, '0, 1'b0, 1'b1);
        repeat (3) cyc(clean, '0, 1'b0, 1'b0);

        // Randomized traffic, with occasional held mismatches to reach saturation.
        hold = 0; hold_pat = bad1;
        for (int n = 0; n < 1500; n++) begin
            logic [NF*KW-1:0] kc;
            logic [NF-1:0]    m;
            logic [KW-1:0]    base;
            int               r, fb;
            base = ($urandom_range(1, 0) == 1) ? 8'hBC : 8'h3C;
            kc   = {NF{base}};
            r    = $urandom_range(99, 0);
            fb   = $urandom_range(NF - 1, 0);
            if (hold > 0) begin
                kc = hold_pat; hold--;
            end else if (r < 15) begin
                kc[fb*KW +: KW] = KW'($urandom);
            end else if (r < 25) begin
                kc[fb*KW +: KW] = OVF;
                kc[((fb + 1) % NF)*KW +: KW] = KW'($urandom);
            end else if (r < 30) begin
                kc = $urandom;
            end else if (r < 32) begin
                hold = $urandom_range(40, 10);
                hold_pat = $urandom;
            end
            m = ($urandom_range(9, 0) < 8) ? '0 : NF'($urandom);
            cyc(kc, m, ($urandom_range(99, 0) < 3), ($urandom_range(199, 0) < 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
